// File: rtl/lsu_data_mem_responder.sv
// lsu_data_mem_responder: load/store responder with configurable wait states, lane steering and access checks.
module lsu_data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [2:0]  size_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic        valid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        busy_o
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;
  localparam logic [3:0] WLOAD = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic we_q;
  logic [2:0] size_q;
  logic [31:0] addr_q, wdata_q, rdata_q, rdata_d;
  logic err_q, err_d;
  logic [31:0] mem [DEPTH_WORDS];
  logic idle, go, we, wr;
  logic [2:0] sz;
  logic [31:0] a, wd, word, wsh;
  logic [15:0] sh;
  logic [3:0] be;
  logic [AW-1:0] idx;
  assign idle = state_q == IDLE;
  // With zero wait states the commit edge is the acceptance edge, so live inputs feed the datapath
  assign a  = idle ? addr_i  : addr_q;
  assign we = idle ? we_i    : we_q;
  assign sz = idle ? size_i  : size_q;
  assign wd = idle ? wdata_i : wdata_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (idle && req_i) begin
      state_d = WAIT_CYCLES == 0 ? RESP : WAIT;
      cnt_d   = WLOAD;
    end else if (state_q == WAIT) begin
      state_d = cnt_q == 4'd0 ? RESP : WAIT;
      cnt_d   = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
    end else if (state_q == RESP) begin
      state_d = IDLE;
    end
  end
  assign go   = state_d == RESP;
  assign idx  = a[AW+1:2];
  assign word = mem[idx];
  assign sh   = 16'(word >> {a[1:0], 3'b000});
  assign wsh  = wd << {a[1:0], 3'b000};
  assign be   = sz[1] ? 4'hf : (sz[0] ? 4'b0011 : 4'b0001) << a[1:0];
  assign err_d = ((a >> (AW + 2)) != 32'd0) || sz == 3'd3 || sz[2:1] == 2'b11 || (we && sz[2]) ||
                 (sz[1:0] == 2'b01 && a[0]) || (sz == 3'd2 && a[1:0] != 2'b00);
  assign rdata_d = (err_d || we) ? 32'd0 :
                   sz[1] ? word :
                   sz[0] ? {{16{~sz[2] & sh[15]}}, sh} :
                           {{24{~sz[2] & sh[7]}}, sh[7:0]};
  assign wr = go && we && !err_d;
  always_ff @(posedge clk) begin
    if (wr)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wsh[8*i +: 8];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      size_q  <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (idle && req_i) begin
        we_q    <= we_i;
        size_q  <= size_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
      end
      if (go) begin
        rdata_q <= rdata_d;
        err_q   <= err_d;
      end
    end
  end
  assign ready_o = idle;
  assign busy_o  = !idle;
  assign valid_o = state_q == RESP;
  assign rdata_o = rdata_q;
  assign err_o   = err_q;
endmodule

// File: doc/lsu_data_mem_responder.md
Name:
lsu_data_mem_responder

Overview:
Memory-side responder for the core's load/store port. It accepts one load or store per handshake and inserts a configurable number of wait states. It performs byte-lane steering for stores and sign/zero extension for loads, and flags misaligned, out-of-range and illegal-size accesses. It replaces the zero-latency data memory so the core's memory stage can be exercised against realistic, stalling memory timing.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words of storage; power of two, at least 4.
WAIT_CYCLES, 2, wait states between request acceptance and response; 0 to 15.

Ports:
clk  input  1  clock
reset  input  1  reset, asynchronous, active-high
req_i  input  1  request valid
we_i  input  1  1 = store, 0 = load
size_i  input  3  access size: 0=B, 1=H, 2=W, 4=BU, 5=HU
addr_i  input  32  byte address
wdata_i  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
ready_o  output  1  responder can accept a request this cycle
valid_o  output  1  response valid, one-cycle pulse
rdata_o  output  32  extended load data; 0 for stores and errors
err_o  output  1  access error, qualified by valid_o
busy_o  output  1  request in flight (~ready_o)

Behaviour:
- Reset (async, active-high): state IDLE; ready_o=1; valid_o=0; rdata_o=0; err_o=0; busy_o=0; wait counter=0. Storage array is not cleared.
- States: IDLE, WAIT, RESP.
- IDLE:
  - ready_o=1.
  - req_i=1 at a clock edge accepts the request: addr, we, size and wdata are captured into holding registers.
  - Next state is WAIT with counter=WAIT_CYCLES-1, or RESP if WAIT_CYCLES=0.
  - Inputs are ignored outside IDLE.
- WAIT:
  - ready_o=0.
  - Counter decrements each cycle; when counter=0, go to RESP.
- Commit point: the edge entering RESP.
  - Store: memory is written.
  - Load: memory is read and extended into rdata_o.
  - err_o is registered at the same edge.
- RESP:
  - valid_o=1 for exactly one cycle; ready_o=0.
  - Next state is IDLE unconditionally.
  - rdata_o and err_o hold their values until the next commit.
- Timing:
  - Request accepted in cycle 0 gives valid_o in cycle 1+WAIT_CYCLES.
  - Next acceptance possible in cycle 2+WAIT_CYCLES.
  - Maximum throughput is one access per WAIT_CYCLES+2 cycles.
- Addressing:
  - Little-endian.
  - Word index = addr[2+log2(DEPTH_WORDS)-1:2]; byte lane = addr[1:0].
- Error conditions (any one sets err_o=1, suppresses the write, forces rdata_o=0):
  - addr >= 4*DEPTH_WORDS.
  - H/HU with addr[0]=1.
  - W with addr[1:0]!=0.
  - size in {3,6,7}.
  - we_i=1 with size 4 or 5.
- Stores: only the addressed byte or half lanes are modified; other lanes are preserved.
- Load extension:
  - B sign-extends the selected byte; BU zero-extends it.
  - H sign-extends the selected half; HU zero-extends it.
  - W returns the word unchanged.
- A store's rdata_o is 0.
- A load after a store to the same address sees the new data (writes commit before any later read).
- Reset in WAIT or RESP: the transaction is aborted and state goes to IDLE.
  - A store aborted in WAIT is never written.
  - Storage written before the reset is retained.
- req_i held high across RESP is not re-accepted until IDLE; a held request is then accepted again as a new transaction.

Test Plan:
- Word round trip (WAIT_CYCLES=2): store W 0xDEADBEEF @0x10 in cycle 0 -> valid_o in cycle 3, err_o=0, ready_o=1 in cycle 4. Then load W @0x10 -> rdata_o=0xDEADBEEF.
- Extension (memory @0x10 = 0xDEADBEEF):
  - B @0x13 -> 0xFFFFFFDE; BU @0x13 -> 0x000000DE.
  - H @0x12 -> 0xFFFFDEAD; HU @0x12 -> 0x0000DEAD.
  - B @0x10 -> 0xFFFFFFEF.
- Partial stores (memory @0x10 = 0xDEADBEEF):
  - store B 0x55 @0x11 -> load W @0x10 returns 0xDEAD55EF.
  - then store H 0x1234 @0x12 -> load W @0x10 returns 0x123455EF.
- Errors: each of the following -> err_o=1, rdata_o=0, and a following load W @0x10 is unchanged:
  - load W @0x12; store H @0x13; load size 3 @0x10; store BU @0x10.
  - store W @0x400 with DEPTH_WORDS=256.
- Reset mid-operation: store W 0xCAFEF00D @0x20 after 0x11111111 was stored there; assert reset during WAIT -> all outputs return to reset values immediately, ready_o=1, and load W @0x20 returns 0x11111111.
- Zero wait and held request: with WAIT_CYCLES=0 and req_i held high for 6 cycles (load W @0x10) -> valid_o pulses in cycles 1, 3 and 5, ready_o toggles 1,0,1,0,1,0, and there is never more than one valid_o per two cycles.
